// File: rtl/serial_operand_port.sv
// rtl/serial_operand_port.sv - word-to-bit-serial operand streamer with serial result capture
// Streams two parallel operands LSB-first and reassembles the ALU's serial result bits.
module serial_operand_port #(
    parameter int LENGTH = 32,
    parameter int CW     = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LENGTH-1:0] op_a,
    input  logic [LENGTH-1:0] op_b,
    input  logic              rd_in,
    output logic              rs1_d,
    output logic              rs2_d,
    output logic              reg_write,
    output logic [CW-1:0]     count,
    output logic              busy,
    output logic              done,
    output logic [LENGTH-1:0] result
);
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    localparam logic [CW-1:0] LAST = CW'(LENGTH - 1);

    state_t              state_q, state_d;
    logic [LENGTH-1:0]   sa_q, sa_d;
    logic [LENGTH-1:0]   sb_q, sb_d;
    logic [LENGTH-2:0]   rshift_q, rshift_d;
    logic [CW-1:0]       count_q, count_d;
    logic [LENGTH-1:0]   result_q, result_d;
    logic [LENGTH-1:0]   rs_word;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            rshift_q <= '0;
            count_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            rshift_q <= rshift_d;
            count_q  <= count_d;
            result_q <= result_d;
        end
    end

    // rshift only keeps the upper LENGTH-1 collected bits; bit 0 would fall out next shift anyway
    assign rs_word = {rd_in, rshift_q};

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        rshift_d = rshift_q;
        count_d  = count_q;
        result_d = result_q;
        case (state_q)
            S_SHIFT: begin
                sa_d     = sa_q >> 1;
                sb_d     = sb_q >> 1;
                rshift_d = rs_word[LENGTH-1:1];
                if (count_q == LAST) begin
                    result_d = rs_word;
                    state_d  = S_DONE;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            default: begin
                if (start) begin
                    sa_d     = op_a;
                    sb_d     = op_b;
                    rshift_d = '0;
                    count_d  = '0;
                    state_d  = S_SHIFT;
                end else begin
                    state_d  = S_IDLE;
                end
            end
        endcase
    end

    assign busy      = (state_q == S_SHIFT);
    assign reg_write = busy;
    assign rs1_d     = busy & sa_q[0];
    assign rs2_d     = busy & sb_q[0];
    assign done      = (state_q == S_DONE);
    assign count     = count_q;
    assign result    = result_q;
endmodule

// File: tb/tb_serial_operand_port.sv
// tb/tb_serial_operand_port.sv - checks serial_operand_port at LENGTH=32 and LENGTH=2
// A phase-index model predicts every output each cycle; directed tests pin results and timing.
module tb_serial_operand_port;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic [31:0] op_a0 = '0, op_b0 = '0;
    logic [1:0]  op_a1 = '0, op_b1 = '0;
    logic        rd_in0 = 1'b0, rd_in1 = 1'b0;
    logic        rs1_d0, rs2_d0, rw0, busy0, done0;
    logic        rs1_d1, rs2_d1, rw1, busy1, done1;
    logic [6:0]  count0;
    logic [1:0]  count1;
    logic [31:0] result0;
    logic [1:0]  result1;

    int n_cmp = 0;
    int n_bad = 0;
    logic mode_pass = 1'b0;
    logic armed = 1'b0;

    serial_operand_port #(.LENGTH(32), .CW(7)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .op_a(op_a0), .op_b(op_b0), .rd_in(rd_in0),
        .rs1_d(rs1_d0), .rs2_d(rs2_d0), .reg_write(rw0), .count(count0), .busy(busy0),
        .done(done0), .result(result0));

    serial_operand_port #(.LENGTH(2), .CW(2)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .op_a(op_a1), .op_b(op_b1), .rd_in(rd_in1),
        .rs1_d(rs1_d1), .rs2_d(rs2_d1), .reg_write(rw1), .count(count1), .busy(busy1),
        .done(done1), .result(result1));

    always #5 clk = ~clk;

    // ALU stand-in: reacts on the falling edge inside each cycle
    always @(negedge clk) begin
        rd_in0 = mode_pass ? rs1_d0 : (rs1_d0 ^ rs2_d0);
        rd_in1 = mode_pass ? rs1_d1 : (rs1_d1 ^ rs2_d1);
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: phase -1 idle, 0..len-1 carrying bit phase, len = done cycle
    int           len[2] = '{32, 2};
    int           m_phase[2] = '{-1, -1};
    int           m_cnt[2] = '{0, 0};
    logic [127:0] m_a[2], m_b[2], m_acc[2], m_res[2];

    task automatic model_step(input int i, input logic rst, input logic st,
                              input logic [127:0] a, input logic [127:0] b, input logic rd);
        if (rst) begin
            m_phase[i] = -1;
            m_cnt[i]   = 0;
            m_res[i]   = '0;
            m_acc[i]   = '0;
        end else if (m_phase[i] >= 0 && m_phase[i] < len[i]) begin
            m_acc[i][m_phase[i]] = rd;
            if (m_phase[i] == len[i] - 1) begin
                m_res[i]   = m_acc[i];
                m_phase[i] = len[i];
            end else begin
                m_phase[i] = m_phase[i] + 1;
                m_cnt[i]   = m_phase[i];
            end
        end else if (st) begin
            m_a[i]     = a;
            m_b[i]     = b;
            m_acc[i]   = '0;
            m_cnt[i]   = 0;
            m_phase[i] = 0;
        end else begin
            m_phase[i] = -1;
        end
    endtask

    always @(posedge clk) begin
        model_step(0, reset, start0, 128'(op_a0), 128'(op_b0), rd_in0);
        model_step(1, reset, start1, 128'(op_a1), 128'(op_b1), rd_in1);
    end

    task automatic compare_one(input int i, input logic rs1, input logic rs2, input logic rw,
                               input logic bsy, input logic dn, input logic [127:0] cnt,
                               input logic [127:0] res);
        logic sh;
        sh = (m_phase[i] >= 0) && (m_phase[i] < len[i]);
        chk($sformatf("u%0d_rs1_d", i), rs1, sh ? m_a[i][m_phase[i]] : 1'b0);
        chk($sformatf("u%0d_rs2_d", i), rs2, sh ? m_b[i][m_phase[i]] : 1'b0);
        chk($sformatf("u%0d_reg_write", i), rw, sh);
        chk($sformatf("u%0d_busy", i), bsy, sh);
        chk($sformatf("u%0d_done", i), dn, m_phase[i] == len[i]);
        chk($sformatf("u%0d_count", i), cnt, 128'(m_cnt[i]));
        chk($sformatf("u%0d_result", i), res, m_res[i]);
    endtask

    always @(negedge clk) begin
        if (armed) begin
            compare_one(0, rs1_d0, rs2_d0, rw0, busy0, done0, 128'(count0), 128'(result0));
            compare_one(1, rs1_d1, rs2_d1, rw1, busy1, done1, 128'(count1), 128'(result1));
        end
    end

    // Pulse start on unit i, then observe until done (bounded); n=1 is SHIFT cycle 0
    task automatic go(input int i, input logic [31:0] a, input logic [31:0] b,
                      output int done_at, output int rw_cnt);
        if (i == 0) begin op_a0 = a; op_b0 = b; start0 = 1'b1; end
        else begin op_a1 = a[1:0]; op_b1 = b[1:0]; start1 = 1'b1; end
        done_at = -1;
        rw_cnt  = 0;
        for (int n = 1; n <= 60 && done_at < 0; n++) begin
            @(negedge clk);
            if ((i == 0) ? rw0 : rw1) rw_cnt++;
            if ((i == 0) ? done0 : done1) done_at = n;
            if (n == 1) begin
                #1;
                start0 = 1'b0;
                start1 = 1'b0;
            end
        end
        #1;
    endtask

    int d_at, rw_n, d1, d2, ndone;

    initial begin
        repeat (3) @(negedge clk);
        armed = 1'b1;
        #1 reset = 1'b0;
        chk("rst_busy", busy0, 1'b0);
        chk("rst_count", 128'(count0), 0);
        chk("rst_result", 128'(result0), 0);

        // XOR of 5 and 3
        mode_pass = 1'b0;
        go(0, 32'h5, 32'h3, d_at, rw_n);
        chk("t1_done_at", d_at, 33);
        chk("t1_reg_write_cycles", rw_n, 32);
        chk("t1_result", 128'(result0), 128'h6);

        // pass-through capture
        mode_pass = 1'b1;
        go(0, 32'hDEAD_BEEF, 32'h0, d_at, rw_n);
        chk("t2_result", 128'(result0), 128'hDEAD_BEEF);
        chk("t2_count_done", 128'(count0), 31);
        repeat (3) @(negedge clk);
        chk("t2_count_hold", 128'(count0), 31);
        #1;

        // back-to-back with start held high
        op_a0 = 32'h1; op_b0 = 32'h0; start0 = 1'b1;
        d1 = -1; d2 = -1;
        for (int n = 1; n <= 100 && d2 < 0; n++) begin
            @(negedge clk);
            if (d1 >= 0 && n == d1 + 1) chk("t3_second_shift_start", busy0, 1'b1);
            if (done0) begin
                if (d1 < 0) begin
                    d1 = n;
                    chk("t3_result1", 128'(result0), 128'h1);
                end else begin
                    d2 = n;
                    chk("t3_result2", 128'(result0), 128'h8000_0000);
                    #1 start0 = 1'b0;
                end
            end else if (n == 1) begin
                #1 op_a0 = 32'h8000_0000;
            end
        end
        chk("t3_first_done", d1, 33);
        chk("t3_spacing", d2 - d1, 33);
        #1;

        // start while busy is ignored
        mode_pass = 1'b0;
        op_a0 = 32'h0F0F; op_b0 = 32'h00FF; start0 = 1'b1;
        ndone = 0;
        for (int n = 1; n <= 80; n++) begin
            @(negedge clk);
            if (done0) ndone++;
            if (n == 1) begin
                #1 start0 = 1'b0;
            end else if (n == 11) begin
                #1 start0 = 1'b1; op_a0 = 32'hFFFF_FFFF; op_b0 = 32'h0;
            end else if (n == 12) begin
                #1 start0 = 1'b0;
            end
        end
        chk("t4_done_count", ndone, 1);
        chk("t4_result", 128'(result0), 128'h0FF0);
        #1;

        // reset mid-operation, then a fresh op
        op_a0 = 32'h1234; op_b0 = 32'h4321; start0 = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            if (n == 1) begin
                #1 start0 = 1'b0;
            end
        end
        #1 reset = 1'b1;
        @(negedge clk);
        chk("t5_busy", busy0, 1'b0);
        chk("t5_reg_write", rw0, 1'b0);
        chk("t5_count", 128'(count0), 0);
        chk("t5_result", 128'(result0), 0);
        #1 reset = 1'b0;
        ndone = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (done0) ndone++;
        end
        chk("t5_no_done", ndone, 0);
        #1;
        go(0, 32'hA5, 32'h5A, d_at, rw_n);
        chk("t5_fresh_done_at", d_at, 33);
        chk("t5_fresh_result", 128'(result0), 128'hFF);

        // minimum width unit
        mode_pass = 1'b1;
        go(1, 32'h2, 32'h0, d_at, rw_n);
        chk("t6_done_at", d_at, 3);
        chk("t6_reg_write_cycles", rw_n, 2);
        chk("t6_result", 128'(result1), 128'h2);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
